// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle.
// Master side is the keypad/host, slave side is the scanner.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear;
    logic [15:0] number;
    logic [2:0]  digits;
    logic        key_valid;
    logic [3:0]  key_code;

    modport master (
        output row, clear,
        input  col, number, digits, key_valid, key_code
    );

    modport slave (
        input  row, clear,
        output col, number, digits, key_valid, key_code
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame debounce.
// Accepted hex digits shift into a 4-digit number register.
module keypad_scanner #(
    parameter int SCAN_DIV = 5000,
    parameter int DEBOUNCE = 4
) (
    input logic             clk,
    input logic             reset,
    keypad_scanner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAND, HELD, REL} state_t;

    logic [3:0]  row_s1, row_s2;
    logic [15:0] div_cnt;
    logic [1:0]  col_idx;
    logic        last, frame_end;
    logic [1:0]  col_hits, acc_hits, base_hits, frame_hits;
    logic [3:0]  col_code, acc_code, base_code, frame_code;
    logic [2:0]  hit_sum;
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n, cand, cand_n;
    logic        accept;
    logic [15:0] number;
    logic [2:0]  digits;
    logic        key_valid;
    logic [3:0]  key_code;

    assign last      = (div_cnt == 16'(SCAN_DIV - 1));
    assign frame_end = last && (col_idx == 2'd3);
    assign bus.col   = ~(4'b0001 << col_idx);

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= bus.row;
            row_s2 <= row_s1;
        end
    end

    // Column dwell counter and column index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            col_idx <= '0;
        end else if (last) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Classify current column and merge into the frame result
    always_comb begin
        col_hits = 2'd0;
        col_code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
                col_code = {2'(r), col_idx};
            end
        end
        base_hits  = (col_idx == 2'd0) ? 2'd0 : acc_hits;
        base_code  = (col_idx == 2'd0) ? 4'd0 : acc_code;
        hit_sum    = {1'b0, base_hits} + {1'b0, col_hits};
        frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code = (col_hits != 2'd0) ? col_code : base_code;
    end

    // Frame accumulator, updated on each column's sample cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_hits <= '0;
            acc_code <= '0;
        end else if (last) begin
            acc_hits <= frame_hits;
            acc_code <= frame_code;
        end
    end

    // Debounce state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
        end
    end

    // Debounce next-state logic, evaluated only at frame end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (frame_hits == 2'd1) begin
                        cand_n = frame_code;
                        if (DEBOUNCE == 1) begin
                            accept  = 1'b1;
                            state_n = HELD;
                        end else begin
                            state_n = CAND;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                CAND: begin
                    if (frame_hits == 2'd1) begin
                        if (frame_code == cand) begin
                            cnt_n = cnt + 4'd1;
                            if (cnt + 4'd1 == 4'(DEBOUNCE)) begin
                                accept  = 1'b1;
                                state_n = HELD;
                            end
                        end else begin
                            cand_n = frame_code;
                            cnt_n  = 4'd1;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (frame_hits == 2'd0) begin
                        if (DEBOUNCE == 1) begin
                            state_n = IDLE;
                        end else begin
                            state_n = REL;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                REL: begin
                    if (frame_hits == 2'd0) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt + 4'd1 == 4'(DEBOUNCE)) begin
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
            endcase
        end
    end

    // Output registers; clear overrides the number but not the key pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            number    <= '0;
            digits    <= '0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= cand_n;
            end
            if (bus.clear) begin
                number <= '0;
                digits <= '0;
            end else if (accept) begin
                number <= {number[11:0], cand_n};
                digits <= (digits == 3'd4) ? 3'd4 : digits + 3'd1;
            end
        end
    end

    assign bus.number    = number;
    assign bus.digits    = digits;
    assign bus.key_valid = key_valid;
    assign bus.key_code  = key_code;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: simulated key matrix plus a
// frame-level behavioural model checked every cycle.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 2;
    localparam int FR = 4 * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [15:0] mask = '0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner_if bus();

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE(DB)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    // Key matrix: a pressed key shorts its column to its row
    always_comb begin
        bus.row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!bus.col[c])
                for (int r = 0; r < 4; r++)
                    if (mask[4 * r + c]) bus.row[r] = 1'b0;
    end
    assign bus.clear = clr;

    int total = 0;
    int bad = 0;
    int t = 0;
    int kv_seen = 0;

    logic [15:0] m_num;
    int          m_dig;
    logic        m_kv;
    logic [3:0]  m_kc;
    bit          locked;
    int          run_len, none_run;
    logic [3:0]  run_key;

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0d: got=%0h exp=%0h", name, t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_num = '0; m_dig = 0; m_kv = 0; m_kc = '0;
        locked = 0; run_len = 0; none_run = 0; run_key = '0;
    endtask

    // A key is taken once DB identical single-key frames run back to back;
    // afterwards it stays locked until DB consecutive empty frames.
    task automatic frame_eval(output bit acc, output logic [3:0] k);
        int pop;
        pop = $countones(mask);
        acc = 0;
        k = '0;
        for (int i = 0; i < 16; i++) if (mask[i]) k = 4'(i);
        if (locked) begin
            if (pop == 0) begin
                none_run++;
                if (none_run >= DB) begin
                    locked = 0;
                    run_len = 0;
                end
            end else begin
                none_run = 0;
            end
        end else if (pop == 1) begin
            if (run_len > 0 && k == run_key) run_len++;
            else begin
                run_key = k;
                run_len = 1;
            end
            if (run_len >= DB) begin
                acc = 1;
                locked = 1;
                none_run = 0;
                run_len = 0;
            end
        end else begin
            run_len = 0;
        end
    endtask

    task automatic step();
        bit acc;
        logic [3:0] k;
        logic [3:0] e_col;
        @(posedge clk);
        t++;
        acc = 0;
        k = '0;
        if (t % FR == 0) frame_eval(acc, k);
        m_kv = acc;
        if (acc) m_kc = k;
        if (clr) begin
            m_num = '0;
            m_dig = 0;
        end else if (acc) begin
            m_num = {m_num[11:0], k};
            if (m_dig < 4) m_dig++;
        end
        e_col = ~(4'b0001 << ((t / SD) % 4));
        #1;
        chk("col", 16'(bus.col), 16'(e_col));
        chk("key_valid", 16'(bus.key_valid), 16'(m_kv));
        chk("key_code", 16'(bus.key_code), 16'(m_kc));
        chk("number", bus.number, m_num);
        chk("digits", 16'(bus.digits), 16'(m_dig));
        if (bus.key_valid) kv_seen++;
    endtask

    task automatic run_frames(input logic [15:0] m, input int n);
        mask = m;
        repeat (FR * n) step();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_col"}, 16'(bus.col), 16'hE);
        chk({tag, "_number"}, bus.number, 16'h0);
        chk({tag, "_digits"}, 16'(bus.digits), 16'h0);
        chk({tag, "_kv"}, 16'(bus.key_valid), 16'h0);
        chk({tag, "_kc"}, 16'(bus.key_code), 16'h0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1 check_reset(tag);
        repeat (2) @(posedge clk);
        #1 check_reset(tag);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        model_reset();
    endtask

    int kv0;

    initial begin
        model_reset();
        #1 do_reset("por");

        // Idle scanning with no keys
        run_frames(16'h0, 3);
        chk("idle_pulses", 16'(kv_seen), 16'd0);
        chk("idle_number", bus.number, 16'h0000);

        // Key r=1 c=2 (code 6) held, then released
        kv0 = kv_seen;
        run_frames(16'h1 << 6, 4);
        run_frames(16'h0, 3);
        chk("k6_pulses", 16'(kv_seen - kv0), 16'd1);
        chk("k6_code", 16'(bus.key_code), 16'h6);
        chk("k6_number", bus.number, 16'h0006);
        chk("k6_digits", 16'(bus.digits), 16'd1);

        // Codes 1..5 in turn
        for (int k = 1; k <= 5; k++) begin
            run_frames(16'h1 << k, 3);
            run_frames(16'h0, 3);
        end
        chk("seq_number", bus.number, 16'h2345);
        chk("seq_digits", 16'(bus.digits), 16'd4);

        // Short press and a two-key chord
        kv0 = kv_seen;
        run_frames(16'h1 << 3, 1);
        run_frames(16'h0, 3);
        run_frames(16'h0012, 4);
        run_frames(16'h0, 3);
        chk("reject_pulses", 16'(kv_seen - kv0), 16'd0);

        // Clear on the same edge as the accept of code A
        mask = 16'h1 << 10;
        repeat (FR) step();
        repeat (FR - 1) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_kv", 16'(bus.key_valid), 16'h1);
        chk("clr_code", 16'(bus.key_code), 16'hA);
        chk("clr_number", bus.number, 16'h0000);
        chk("clr_digits", 16'(bus.digits), 16'd0);
        run_frames(16'h0, 3);

        // Reset during the second matching frame of code 9
        kv0 = kv_seen;
        mask = 16'h1 << 9;
        repeat (FR) step();
        repeat (FR / 2) step();
        do_reset("mid");
        chk("mid_pulses", 16'(kv_seen - kv0), 16'd0);
        repeat (FR) step();
        chk("fresh1_pulses", 16'(kv_seen - kv0), 16'd0);
        repeat (FR) step();
        chk("fresh2_pulses", 16'(kv_seen - kv0), 16'd1);
        chk("fresh2_code", 16'(bus.key_code), 16'h9);
        chk("fresh2_number", bus.number, 16'h0009);
        run_frames(16'h0, 2);

        // Randomized key activity with sporadic clears
        for (int it = 0; it < 40; it++) begin
            int kind, nfr, a, b;
            kind = int'($urandom_range(0, 9));
            nfr = int'($urandom_range(1, 4));
            a = int'($urandom_range(0, 15));
            b = (a + int'($urandom_range(1, 15))) % 16;
            if (kind < 4) mask = 16'h0;
            else if (kind < 8) mask = 16'h1 << a;
            else mask = (16'h1 << a) | (16'h1 << b);
            repeat (FR * nfr) begin
                clr = ($urandom_range(0, 39) == 0);
                step();
            end
            clr = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 5000, meaning clk cycles each column is driven (legal range 4..65535).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, meaning the number of consecutive identical scan frames needed to accept a press or a release (legal range 1..15).
REQ-003 Port clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port row  input  4  carries the keypad row lines; they are active-low (pulled up) and asynchronous to clk.
REQ-006 Port col  output  4  drives the keypad columns; exactly one bit SHALL be low at any time.
REQ-007 Port clear  input  1  is a synchronous request to clear the entered number.
REQ-008 Port number  output  16  holds the last four accepted hex digits, newest digit in [3:0], in a form directly consumable by the 4-digit display driver.
REQ-009 Port digits  output  3  gives the count of accepted digits since reset or clear, saturating at 4.
REQ-010 Port key_valid  output  1  SHALL pulse high for one cycle per accepted key.
REQ-011 Port key_code  output  4  SHALL hold the code of the most recently accepted key.

Function
REQ-012 The row input SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The col output SHALL step through 1110, 1101, 1011, 0111 and then wrap, holding each value for exactly SCAN_DIV cycles.
- Column index c = 0..3 in that order.
REQ-014 The synchronized row SHALL be sampled only on the last cycle of each column dwell, so the row lines settle and the synchronizer latency is covered.
REQ-015 A key at row index r (row[r] low) and column c SHALL have code = 4*r + c.
REQ-016 One frame SHALL be 4 consecutive column dwells, starting at column 0.
- Frame result is NONE (no row low in any column), SINGLE(code) (exactly one key low), or MULTI (two or more keys low).
- The result SHALL be evaluated once, at the end of the column-3 dwell.
REQ-017 The debounce FSM SHALL have states IDLE, CAND, HELD and REL, and a match counter; the FSM SHALL update only at frame end.
REQ-018 IDLE: on SINGLE(k), go to CAND with cand=k and count=1; on NONE or MULTI, stay in IDLE.
REQ-019 CAND: the FSM SHALL behave as follows.
- SINGLE(cand): count+1; if the new count equals DEBOUNCE, accept cand and go to HELD.
- SINGLE(other k): cand=k, count=1.
- NONE or MULTI: go to IDLE.
REQ-020 With DEBOUNCE=1, the FSM SHALL accept from IDLE on the first SINGLE frame, passing through CAND in zero frames.
REQ-021 HELD: on NONE, go to REL with count=1 (go directly to IDLE if DEBOUNCE=1); on SINGLE or MULTI, stay in HELD; no repeat accepts.
REQ-022 REL: NONE SHALL increment count and go to IDLE when count reaches DEBOUNCE; SINGLE or MULTI SHALL return to HELD.
REQ-023 On accept, in the cycle after the frame-end sample edge, the block SHALL:
- pulse key_valid for one cycle;
- set key_code=cand;
- set number={number[11:0], cand};
- set digits=min(digits+1, 4).
REQ-024 When digits is already 4, further accepts SHALL still shift number, dropping the oldest digit, and digits SHALL stay at 4.
REQ-025 clear SHALL set number=0 and digits=0 on the next edge and SHALL NOT affect the scan or the FSM.
REQ-026 If clear and an accept occur on the same edge, clear SHALL win for number and digits (both end at 0), while key_valid still pulses and key_code still updates.
REQ-027 Keys pressed during the accepting frame that are not cand SHALL be ignored until the FSM next leaves IDLE.

Reset
REQ-028 While reset is low, the block SHALL hold:
- col=1110, number=0, digits=0, key_valid=0, key_code=0;
- FSM state IDLE, scan and match counters 0, synchronizer flops 1111.
REQ-029 Reset asserted mid-frame or mid-debounce SHALL abort all activity with no key_valid pulse; after release, scanning SHALL restart at column 0 with a fresh frame.

Verification (SCAN_DIV=4, DEBOUNCE=2)
REQ-030 Reset, no keys for 3 frames -> col sequence 1110,1101,1011,0111 with 4 cycles each; key_valid never asserts; number=0000.
REQ-031 Hold key r=1,c=2 (code 6) for 4 frames, then release -> exactly one key_valid, key_code=6, number=0006, digits=1.
REQ-032 Press and release codes 1,2,3,4,5 in turn, each held 3 frames with 3 frames released between -> number=2345, digits=4 after the fifth key.
REQ-033 Press a key for only 1 frame, or press two keys together for 4 frames -> no key_valid.
REQ-034 Drive clear on the key_valid edge of code A -> key_valid=1, key_code=A, number=0000, digits=0.
REQ-035 Assert reset during the second matching frame of a held key -> outputs at reset values; no key_valid; after release the held key is accepted only after 2 full fresh frames.
